idt_issue_queue: RTL and testbench
==================================

# idt_issue_queue

Parametrised successor to the instruction dependency table. It tracks per-entry dependency vectors for a BS-entry instruction buffer, accepts NC completion (wakeup) broadcasts per cycle, and selects one ready instruction per cycle for issue with a round-robin valid/ready handshake. It sits between the decode/rename stage, which allocates entries, and the execution units, which consume issued indices and report completions.

## Interface
- BS, 16: buffer entries; power of two, ≥4.
- NC, 2: completion ports per cycle, 1..4.
- IW, $clog2(BS): index width (derived; do not override).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- alloc_valid  in  1  allocation request.
- alloc_idx  in  IW  entry to allocate.
- alloc_dep  in  BS  producer entries this instruction waits on (bit j = waits on entry j).
- alloc_ready  out  1  entry alloc_idx is FREE (combinational from state).
- cmp_valid  in  NC  completion strobe per port.
- cmp_idx  in  NC*IW  completing entry per port; port k at bits [k*IW +: IW].
- issue_valid  out  1  a READY entry exists.
- issue_idx  out  IW  selected entry.
- issue_ready  in  1  consumer accepts issue_idx.
- flush  in  1  discard all entries.
- ready_vec  out  BS  per-entry READY flags.
- occupancy  out  IW+1  count of non-FREE entries.
- cmp_err  out  1  one-cycle pulse: a completion named an entry not in ISSUED.

## Operation
- Per-entry state: FREE, WAIT, READY, ISSUED. Each entry also holds a BS-bit dependency row.
- Allocation fires on alloc_valid & alloc_ready. The entry goes to WAIT with row = alloc_dep masked by: own bit, bits of FREE entries, and bits of entries completing in the same cycle. If the masked row is zero, the entry goes directly to READY.
- alloc_valid with alloc_ready=0 has no effect; the requester must hold the request.
- A completion on port k fires when cmp_valid[k]=1 and entry cmp_idx[k] is ISSUED. That entry goes to FREE, its row is cleared, and column cmp_idx[k] is cleared in every row.
- A completion naming a non-ISSUED entry is ignored: no state or column change, and cmp_err pulses next cycle.
- Duplicate indices across ports in one cycle count as a single completion with no error.
- A WAIT entry whose row becomes zero, after this cycle's column clears, enters READY at the edge.
- Issue select is a round-robin search over ready_vec, starting at rr_ptr. issue_valid = |ready_vec.
- On issue_valid & issue_ready, entry issue_idx goes to ISSUED and rr_ptr becomes issue_idx+1 mod BS. Without a handshake, issue_idx and rr_ptr stay unchanged.
- Precedence per cycle: rst > flush > completions > issue > allocation.
- flush sets all entries to FREE and all rows and rr_ptr to 0. Concurrent alloc and issue handshakes are discarded.
- occupancy counts non-FREE entries after the update.

## Timing
- Reset values: all entries FREE, rows 0, rr_ptr 0. Outputs: alloc_ready=1 for any index, issue_valid=0, issue_idx=0, ready_vec=0, occupancy=0, cmp_err=0.
- Allocation to READY: an entry with no live dependencies shows in ready_vec and can be issued the cycle after allocation.
- Wakeup latency: completion at edge N; a dependent whose last dependency was that producer is READY and issuable in cycle N+1.
- The same entry index can complete and be re-allocated in consecutive cycles, not in the same cycle: alloc_ready reflects the pre-edge state.
- issue_valid, issue_idx and ready_vec are combinational from registered state only; there is no combinational path from issue_ready.
- Mid-operation reset clears everything at the next edge, regardless of handshakes in flight.

## Structure
- Shared package idt_pkg holds the entry_state_t enum (FREE=2'd0, WAIT, READY, ISSUED) and the BS/NC default localparams.
- Sub-module rr_picker: BS-wide round-robin find-first-set from a start pointer. Outputs found and index. Instantiated once for issue selection.
- The top level holds the state and row arrays, the completion column-clear network (OR of NC one-hot decodes), and the occupancy popcount.

## Test plan
- Reset then idle: after rst low for 2 cycles, ready_vec=0, occupancy=0, issue_valid=0, alloc_ready=1.
- Chain: alloc 3 (dep 0) issues. Alloc 5 with dep bit 3 stays in WAIT. Issue 3, then complete 3 at edge N: ready_vec[5]=1 and issue_idx=5 in cycle N+1.
- Multi-complete: entry 7 depends on 1 and 2, both ISSUED. Complete 1 and 2 on ports 0 and 1 in the same cycle: entry 7 is READY next cycle. Completing only 1 leaves it in WAIT.
- Round-robin: entries 2, 9 and 14 READY with issue_ready=1 held: issue order 2, 9, 14. Re-ready 2 and 9 after rr_ptr=15: order 2, 9.
- Same-cycle masking: alloc 4 with dep bit 6 in the same cycle that 6 completes: entry 4 is READY next cycle. Alloc to an occupied entry: alloc_ready=0 and state unchanged.
- Errors and flush: complete entry 8 while it is in WAIT: cmp_err pulses once and entry 8 stays in WAIT. flush with 10 entries occupied: occupancy=0 and issue_valid=0 next cycle.

Source files
------------

// File: rtl/idt_pkg.sv
// Shared types and default sizing for the instruction issue queue.
package idt_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } entry_state_t;

  localparam int BS_DEFAULT = 16;
  localparam int NC_DEFAULT = 2;

endpackage

// File: rtl/idt_issue_queue_rr_picker.sv
// Round-robin find-first-set over a BS-wide request vector, starting at a
// given pointer and wrapping modulo BS (BS is a power of two).
module rr_picker #(
  parameter int BS = 16,
  parameter int IW = $clog2(BS)
) (
  input  logic [BS-1:0] req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic          found_s;
  logic          hit_s;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] cand_s;

  // Walk candidates start, start+1, ... and latch the first requester.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < BS; i++) begin
      cand_s  = start + IW'(i);
      hit_s   = req[cand_s] & ~found_s;
      idx_s   = hit_s ? cand_s : idx_s;
      found_s = found_s | hit_s;
    end
  end

  assign found = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/idt_issue_queue.sv
// Issue queue: per-entry state and dependency rows, completion wakeup network,
// and round-robin issue selection for a BS-entry instruction buffer.
module idt_issue_queue
  import idt_pkg::*;
#(
  parameter  int BS = BS_DEFAULT,
  parameter  int NC = NC_DEFAULT,
  localparam int IW = $clog2(BS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_valid,
  input  logic [IW-1:0]  alloc_idx,
  input  logic [BS-1:0]  alloc_dep,
  output logic           alloc_ready,
  input  logic [NC-1:0]  cmp_valid,
  input  logic [NC*IW-1:0] cmp_idx,
  output logic           issue_valid,
  output logic [IW-1:0]  issue_idx,
  input  logic           issue_ready,
  input  logic           flush,
  output logic [BS-1:0]  ready_vec,
  output logic [IW:0]    occupancy,
  output logic           cmp_err
);

  entry_state_t  state_r    [BS];
  entry_state_t  state_nx_s [BS];
  logic [BS-1:0] row_r      [BS];
  logic [BS-1:0] row_nx_s   [BS];
  logic [IW-1:0] rr_ptr_r;
  logic          cmp_err_r;
  logic [IW:0]   occupancy_r;
  logic [IW:0]   occ_nx_s;

  logic [BS-1:0] free_vec_s;
  logic [BS-1:0] ready_vec_s;
  logic [BS-1:0] cmp_col_s;
  logic [BS-1:0] alloc_row_s;
  logic [IW-1:0] cidx_s;
  logic          cmp_hit_s;
  logic          cmp_bad_s;
  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          issue_fire_s;
  logic          alloc_fire_s;

  // Per-entry FREE and READY flags from registered state.
  always_comb begin
    free_vec_s  = '0;
    ready_vec_s = '0;
    for (int i = 0; i < BS; i++) begin
      free_vec_s[i]  = (state_r[i] == FREE);
      ready_vec_s[i] = (state_r[i] == READY);
    end
  end

  // Completion decode: only ISSUED targets clear their column; anything else flags an error.
  always_comb begin
    cmp_col_s = '0;
    cmp_bad_s = 1'b0;
    cidx_s    = '0;
    cmp_hit_s = 1'b0;
    for (int k = 0; k < NC; k++) begin
      cidx_s    = cmp_idx[k*IW +: IW];
      cmp_hit_s = cmp_valid[k] & (state_r[cidx_s] == ISSUED);
      cmp_col_s = cmp_col_s | (BS'(cmp_hit_s) << cidx_s);
      cmp_bad_s = cmp_bad_s | (cmp_valid[k] & (state_r[cidx_s] != ISSUED));
    end
  end

  rr_picker #(.BS(BS), .IW(IW)) u_pick (
    .req   (ready_vec_s),
    .start (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign issue_fire_s = pick_found_s & issue_ready;
  assign alloc_fire_s = alloc_valid & free_vec_s[alloc_idx];
  // Producers already free, finishing now, or the entry itself can never wake it.
  assign alloc_row_s  = alloc_dep & ~free_vec_s & ~cmp_col_s & ~(BS'(1'b1) << alloc_idx);

  // Next state per entry: free on completion, mark issued, fill on allocation, wake on empty row.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      state_nx_s[i] = state_r[i];
      row_nx_s[i]   = row_r[i] & ~cmp_col_s;
      case (state_r[i])
        FREE: begin
          if (alloc_fire_s && (alloc_idx == IW'(i))) begin
            row_nx_s[i]   = alloc_row_s;
            state_nx_s[i] = (alloc_row_s == '0) ? READY : WAIT;
          end else begin
            row_nx_s[i]   = '0;
          end
        end
        WAIT: state_nx_s[i] = (row_nx_s[i] == '0) ? READY : WAIT;
        READY: begin
          if (issue_fire_s && (pick_idx_s == IW'(i))) begin
            state_nx_s[i] = ISSUED;
          end else begin
            state_nx_s[i] = READY;
          end
        end
        ISSUED: begin
          if (cmp_col_s[i]) begin
            state_nx_s[i] = FREE;
            row_nx_s[i]   = '0;
          end else begin
            state_nx_s[i] = ISSUED;
          end
        end
        default: begin
          state_nx_s[i] = FREE;
          row_nx_s[i]   = '0;
        end
      endcase
    end
  end

  // Post-update occupancy so the registered count matches the new state.
  always_comb begin
    occ_nx_s = '0;
    for (int i = 0; i < BS; i++) begin
      occ_nx_s = occ_nx_s + {{IW{1'b0}}, (state_nx_s[i] != FREE)};
    end
  end

  // State registers; flush behaves as a soft reset of the whole table.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < BS; i++) begin
        state_r[i] <= FREE;
        row_r[i]   <= '0;
      end
      rr_ptr_r    <= '0;
      cmp_err_r   <= 1'b0;
      occupancy_r <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        state_r[i] <= state_nx_s[i];
        row_r[i]   <= row_nx_s[i];
      end
      rr_ptr_r    <= issue_fire_s ? (pick_idx_s + IW'(1)) : rr_ptr_r;
      cmp_err_r   <= cmp_bad_s;
      occupancy_r <= occ_nx_s;
    end
  end

  assign alloc_ready = free_vec_s[alloc_idx];
  assign issue_valid = pick_found_s;
  assign issue_idx   = pick_idx_s;
  assign ready_vec   = ready_vec_s;
  assign occupancy   = occupancy_r;
  assign cmp_err     = cmp_err_r;

endmodule

// File: tb/tb_idt_issue_queue.sv
// Scoreboard bench for idt_issue_queue: a set-based reference model predicts
// every cycle's outputs, a negedge monitor compares, plus directed scenarios.
module tb_idt_issue_queue;

  localparam int BS = 16;
  localparam int NC = 2;
  localparam int IW = 4;
  localparam int M_FREE = 0, M_WAIT = 1, M_READY = 2, M_ISSUED = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [IW-1:0] alloc_idx = '0;
  logic [BS-1:0] alloc_dep = '0;
  logic [NC-1:0] cmp_valid = '0;
  logic [NC*IW-1:0] cmp_idx = '0;
  logic          issue_ready = 1'b0;
  logic          alloc_ready, issue_valid, cmp_err;
  logic [IW-1:0] issue_idx;
  logic [BS-1:0] ready_vec;
  logic [IW:0]   occupancy;

  always #5 clk = ~clk;

  idt_issue_queue #(.BS(BS), .NC(NC)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_dep(alloc_dep), .alloc_ready(alloc_ready), .cmp_valid(cmp_valid),
    .cmp_idx(cmp_idx), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_ready(issue_ready), .flush(flush), .ready_vec(ready_vec),
    .occupancy(occupancy), .cmp_err(cmp_err)
  );

  typedef struct packed {
    logic          iv;
    logic [IW-1:0] ii;
    logic [BS-1:0] rv;
    logic [IW:0]   occ;
    logic          ar;
    logic          ce;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int checks = 0;
  int failures = 0;

  // Reference model: entry states plus the set of producers each entry still waits on.
  int            m_st[BS] = '{default: 0};
  bit [BS-1:0]   m_dep[BS] = '{default: '0};
  int            m_rr = 0;
  bit            m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int m_pick();
    for (int off = 0; off < BS; off++) begin
      int j = (m_rr + off) % BS;
      if (m_st[j] == M_READY) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [BS-1:0] done;
    bit          err;
    bit          was_free[BS];
    int          sel, ai, e;
    if (!rst || flush) begin
      for (int i = 0; i < BS; i++) begin
        m_st[i] = M_FREE;
        m_dep[i] = '0;
      end
      m_rr = 0;
      m_err = 1'b0;
      return;
    end
    done = '0;
    err = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (cmp_valid[k]) begin
        e = int'(cmp_idx[k*IW +: IW]);
        if (m_st[e] == M_ISSUED) done[e] = 1'b1;
        else err = 1'b1;
      end
    end
    sel = m_pick();
    for (int i = 0; i < BS; i++) was_free[i] = (m_st[i] == M_FREE);
    ai = int'(alloc_idx);
    for (int d = 0; d < BS; d++) begin
      if (done[d]) begin
        m_st[d] = M_FREE;
        m_dep[d] = '0;
        for (int r = 0; r < BS; r++) m_dep[r][d] = 1'b0;
      end
    end
    for (int r = 0; r < BS; r++)
      if (m_st[r] == M_WAIT && m_dep[r] == '0) m_st[r] = M_READY;
    if (sel >= 0 && issue_ready) begin
      m_st[sel] = M_ISSUED;
      m_rr = (sel + 1) % BS;
    end
    if (alloc_valid && was_free[ai]) begin
      m_dep[ai] = '0;
      for (int j = 0; j < BS; j++)
        if (alloc_dep[j] && j != ai && !was_free[j] && !done[j]) m_dep[ai][j] = 1'b1;
      m_st[ai] = (m_dep[ai] == '0) ? M_READY : M_WAIT;
    end
    m_err = err;
  endtask

  function automatic exp_t model_expect();
    exp_t x;
    int s = m_pick();
    int occ = 0;
    x.iv = (s >= 0);
    x.ii = (s >= 0) ? IW'(s) : '0;
    x.rv = '0;
    for (int i = 0; i < BS; i++) begin
      x.rv[i] = (m_st[i] == M_READY);
      if (m_st[i] != M_FREE) occ++;
    end
    x.occ = (IW+1)'(occ);
    x.ar = (m_st[alloc_idx] == M_FREE);
    x.ce = m_err;
    return x;
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk("issue_valid", 32'(issue_valid), 32'(mx.iv));
      if (mx.iv) chk("issue_idx", 32'(issue_idx), 32'(mx.ii));
      chk("ready_vec", 32'(ready_vec), 32'(mx.rv));
      chk("occupancy", 32'(occupancy), 32'(mx.occ));
      chk("alloc_ready", 32'(alloc_ready), 32'(mx.ar));
      chk("cmp_err", 32'(cmp_err), 32'(mx.ce));
    end
  end

  // Apply inputs for the next edge, queue the expected outputs, return after the edge.
  task automatic step(input logic r, input logic av, input int ai, input logic [BS-1:0] ad,
                      input logic [NC-1:0] cv, input int c0, input int c1,
                      input logic ir, input logic fl);
    rst = r; alloc_valid = av; alloc_idx = IW'(ai); alloc_dep = ad;
    cmp_valid = cv; cmp_idx = {IW'(c1), IW'(c0)}; issue_ready = ir; flush = fl;
    exp_q.push_back(model_expect());
    @(posedge clk);
    #2;
  endtask

  task automatic nop();                         step(1'b1, 1'b0, 0, '0, '0, 0, 0, 1'b0, 1'b0); endtask
  task automatic al(input int i, input logic [BS-1:0] d, input logic ir); step(1'b1, 1'b1, i, d, '0, 0, 0, ir, 1'b0); endtask
  task automatic iss();                         step(1'b1, 1'b0, 0, '0, '0, 0, 0, 1'b1, 1'b0); endtask
  task automatic cmp(input logic [NC-1:0] v, input int c0, input int c1); step(1'b1, 1'b0, 0, '0, v, c0, c1, 1'b0, 1'b0); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int iss_q[$];
    int c0, c1;
    logic [BS-1:0] rd;
    @(posedge clk); #2;
    step(1'b0, 1'b0, 0, '0, '0, 0, 0, 1'b0, 1'b0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_idx", 32'(issue_idx), 32'd0);
    chk("rst_ready_vec", 32'(ready_vec), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_cmp_err", 32'(cmp_err), 32'd0);

    al(3, '0, 1'b0);
    chk("chain_ready3", 32'(ready_vec), 32'h0008);
    chk("chain_idx3", 32'(issue_idx), 32'd3);
    al(5, 16'h0008, 1'b1);
    chk("chain_wait5", 32'(ready_vec), 32'h0000);
    chk("chain_occ", 32'(occupancy), 32'd2);
    cmp(2'b01, 3, 0);
    chk("wake_ready5", 32'(ready_vec), 32'h0020);
    chk("wake_idx5", 32'(issue_idx), 32'd5);
    chk("wake_valid", 32'(issue_valid), 32'd1);
    iss();
    cmp(2'b01, 5, 0);

    al(1, '0, 1'b0);
    al(2, '0, 1'b1);
    al(4, '0, 1'b1);
    al(7, 16'h0006, 1'b1);
    al(9, 16'h0014, 1'b0);
    cmp(2'b01, 1, 0);
    chk("multi_partial", 32'(ready_vec), 32'h0000);
    cmp(2'b11, 2, 4);
    chk("multi_both", 32'(ready_vec), 32'h0280);
    chk("multi_occ", 32'(occupancy), 32'd2);
    chk("multi_idx7", 32'(issue_idx), 32'd7);
    iss();
    chk("multi_idx9", 32'(issue_idx), 32'd9);
    iss();
    cmp(2'b11, 7, 7);
    chk("dup_no_err", 32'(cmp_err), 32'd0);
    cmp(2'b01, 9, 0);
    chk("drained_occ", 32'(occupancy), 32'd0);

    al(6, '0, 1'b0);
    iss();
    step(1'b1, 1'b1, 4, 16'h0040, 2'b01, 6, 0, 1'b0, 1'b0);
    chk("mask_ready4", 32'(ready_vec), 32'h0010);
    chk("mask_occ", 32'(occupancy), 32'd1);
    al(4, '0, 1'b0);
    chk("occupied_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("occupied_ready_vec", 32'(ready_vec), 32'h0010);
    chk("occupied_occ", 32'(occupancy), 32'd1);

    al(8, 16'h0010, 1'b0);
    cmp(2'b01, 8, 0);
    chk("err_pulse", 32'(cmp_err), 32'd1);
    chk("err_occ", 32'(occupancy), 32'd2);
    chk("err_ready_vec", 32'(ready_vec), 32'h0010);
    nop();
    chk("err_cleared", 32'(cmp_err), 32'd0);

    foreach (iss_q[i]) iss_q.delete();
    for (int e = 0; e < 10; e++) if (e != 4 && e != 8) al(e, '0, 1'b0);
    chk("pre_flush_occ", 32'(occupancy), 32'd10);
    step(1'b1, 1'b1, 10, '0, '0, 0, 0, 1'b1, 1'b1);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    chk("flush_ready_vec", 32'(ready_vec), 32'd0);

    al(2, '0, 1'b0);
    al(9, '0, 1'b0);
    al(14, '0, 1'b0);
    chk("rr_first", 32'(issue_idx), 32'd2);
    iss();
    chk("rr_second", 32'(issue_idx), 32'd9);
    iss();
    chk("rr_third", 32'(issue_idx), 32'd14);
    iss();
    chk("rr_empty", 32'(issue_valid), 32'd0);
    cmp(2'b11, 2, 9);
    al(2, '0, 1'b0);
    al(9, '0, 1'b0);
    chk("rr_wrap_first", 32'(issue_idx), 32'd2);
    iss();
    chk("rr_wrap_second", 32'(issue_idx), 32'd9);
    nop();

    for (int n = 0; n < 3000; n++) begin
      iss_q = {};
      for (int i = 0; i < BS; i++) if (m_st[i] == M_ISSUED) iss_q.push_back(i);
      c0 = (iss_q.size() > 0 && $urandom_range(3) != 0) ? iss_q[$urandom_range(iss_q.size() - 1)]
                                                      : int'($urandom_range(BS - 1));
      c1 = (iss_q.size() > 0 && $urandom_range(3) != 0) ? iss_q[$urandom_range(iss_q.size() - 1)]
                                                      : int'($urandom_range(BS - 1));
      if ($urandom_range(9) == 0) c1 = c0;
      rd = BS'($urandom & $urandom & $urandom);
      step($urandom_range(299) != 0, 1'($urandom_range(1)), int'($urandom_range(BS - 1)), rd,
           NC'($urandom_range(3)), c0, c1, $urandom_range(9) < 6, $urandom_range(99) == 0);
    end
    nop();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
